program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/loader_word_packer.sv | 41 ++++
 rtl/program_loader.sv | 105 ++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding and stream framing constants.
package program_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI  = 3'd0,
        HDR_LO  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words and emits a one-cycle word-ready pulse.
module loader_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_done_o,
    output logic        word_valid_o,
    output logic [31:0] word_data_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [23:0]      assembly_q;

    // Combinational so the parent can update its address in the same cycle the last byte lands.
    assign word_done_o = byte_en_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q        <= '0;
            assembly_q   <= '0;
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
        end else begin
            word_valid_o <= 1'b0;
            if (byte_en_i) begin
                assembly_q <= {assembly_q[15:0], byte_data_i};
                if (word_done_o) begin
                    cnt_q        <= '0;
                    word_valid_o <= 1'b1;
                    word_data_o  <= {assembly_q, byte_data_i};
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream into instruction memory, then releases the CPU.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          imem_we_o,
    output logic [31:0]   imem_addr_o,
    output logic [31:0]   imem_data_o,
    output logic          cpu_start_o,
    output logic          done_o,
    output logic          err_o,
    output loader_state_t dbg_state_o
);

    // Handshake: a byte moves on a rising edge where byte_valid_i && byte_ready_o; ready is registered
    // and depends only on state, and valid low leaves every register untouched.
    loader_state_t state_q;
    logic [7:0]    len_hi_q;
    logic [15:0]   num_words_q;
    logic [31:0]   word_idx_q;
    logic [7:0]    csum_q;
    logic          xfer;
    logic          word_done;
    logic [31:0]   hdr_len;

    assign xfer        = byte_valid_i && byte_ready_o;
    assign hdr_len     = {16'h0, len_hi_q, byte_data_i};
    assign dbg_state_o = state_q;

    loader_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_en_i    (xfer && (state_q == PAYLOAD)),
        .byte_data_i  (byte_data_i),
        .word_done_o  (word_done),
        .word_valid_o (imem_we_o),
        .word_data_o  (imem_data_o)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= HDR_HI;
            len_hi_q     <= '0;
            num_words_q  <= '0;
            word_idx_q   <= '0;
            csum_q       <= '0;
            imem_addr_o  <= '0;
            byte_ready_o <= 1'b1;
            cpu_start_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                HDR_HI: begin
                    len_hi_q <= byte_data_i;
                    state_q  <= HDR_LO;
                end
                HDR_LO: begin
                    num_words_q <= hdr_len[15:0];
                    if (hdr_len == 32'd0) begin
                        state_q <= CHECK;
                    end else if (hdr_len > 32'(MAX_WORDS)) begin
                        state_q      <= ERROR;
                        byte_ready_o <= 1'b0;
                        err_o        <= 1'b1;
                    end else begin
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    csum_q <= csum_q ^ byte_data_i;
                    if (word_done) begin
                        imem_addr_o <= BASE_ADDR + (word_idx_q << 2);
                        word_idx_q  <= word_idx_q + 32'd1;
                        if (word_idx_q == {16'h0, num_words_q} - 32'd1) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    byte_ready_o <= 1'b0;
                    if (byte_data_i == csum_q) begin
                        state_q     <= RUN;
                        done_o      <= 1'b1;
                        cpu_start_o <= 1'b1;
                    end else begin
                        state_q <= ERROR;
                        err_o   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives byte streams and checks writes and final status.
module tb_program_loader;
    import program_loader_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = 8'h00;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [31:0]   imem_addr_o;
    logic [31:0]   imem_data_o;
    logic          cpu_start_o;
    logic          done_o;
    logic          err_o;
    loader_state_t dbg_state_o;

    int tests  = 0;
    int failed = 0;
    int long_pulse = 0;
    int both_flags = 0;
    logic prev_we = 1'b0;
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    logic [31:0] exp_q[$];

    program_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .cpu_start_o  (cpu_start_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // Write monitor: logs every write and flags pulses longer than one cycle.
    always @(negedge clk_i) begin
        if (rst_i && imem_we_o) begin
            obs_addr_q.push_back(imem_addr_o);
            obs_data_q.push_back(imem_data_o);
        end
        if (rst_i && imem_we_o && prev_we) long_pulse++;
        if (done_o && err_o) both_flags++;
        prev_we = rst_i && imem_we_o;
    end

    task automatic apply_reset();
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        obs_addr_q.delete();
        obs_data_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk_i);
        @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        if (byte_ready_o !== 1'b1) begin
            tests++;
            failed++;
            $display("FAIL send_ready: byte_ready_o=%b needed 1 for byte %h", byte_ready_o, b);
        end
        @(posedge clk_i);
        #1 byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        apply_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        tests++; if (dbg_state_o !== HDR_HI) begin failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, HDR_HI); end
        tests++; if (byte_ready_o !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b expected 1", byte_ready_o); end
        tests++; if (imem_we_o !== 1'b0) begin failed++; $display("FAIL reset_we: got %b expected 0", imem_we_o); end
        tests++; if (imem_addr_o !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h expected 0", imem_addr_o); end
        tests++; if (imem_data_o !== 32'h0) begin failed++; $display("FAIL reset_data: got %h expected 0", imem_data_o); end
        tests++; if ({cpu_start_o, done_o, err_o} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b expected 000", {cpu_start_o, done_o, err_o}); end
        rst_i = 1'b1;
    endtask

    task automatic test_single_word();
        apply_reset();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'h24080005, 0);
        send_byte(8'h29, 0);
        settle();
        tests++; if (obs_addr_q.size() != 1) begin failed++; $display("FAIL single_count: got %0d writes expected 1", obs_addr_q.size()); end
        else begin
            tests++; if (obs_addr_q[0] !== 32'h0) begin failed++; $display("FAIL single_addr: got %h expected 0", obs_addr_q[0]); end
            tests++; if (obs_data_q[0] !== 32'h24080005) begin failed++; $display("FAIL single_data: got %h expected 24080005", obs_data_q[0]); end
        end
        tests++; if ({done_o, cpu_start_o, byte_ready_o, err_o} !== 4'b1100) begin failed++; $display("FAIL single_status: done/start/ready/err got %b expected 1100", {done_o, cpu_start_o, byte_ready_o, err_o}); end
        tests++; if (dbg_state_o !== RUN) begin failed++; $display("FAIL single_state: got %0d expected %0d", dbg_state_o, RUN); end
    endtask

    task automatic test_gaps();
        apply_reset();
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h80000001);
        send_byte(8'h00, 2); send_byte(8'h03, 3);
        for (int k = 0; k < 3; k++) send_word(exp_q[k], k + 1);
        send_byte(8'hA7, 2);
        settle();
        tests++; if (obs_addr_q.size() != 3) begin failed++; $display("FAIL gaps_count: got %0d writes expected 3", obs_addr_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                tests++; if (obs_addr_q[k] !== 32'(4 * k)) begin failed++; $display("FAIL gaps_addr%0d: got %h expected %h", k, obs_addr_q[k], 4 * k); end
                tests++; if (obs_data_q[k] !== exp_q[k]) begin failed++; $display("FAIL gaps_data%0d: got %h expected %h", k, obs_data_q[k], exp_q[k]); end
            end
        end
        tests++; if (long_pulse != 0) begin failed++; $display("FAIL gaps_pulse_width: got %0d long pulses expected 0", long_pulse); end
        tests++; if (done_o !== 1'b1) begin failed++; $display("FAIL gaps_done: got %b expected 1", done_o); end
    endtask

    task automatic test_empty();
        apply_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        settle();
        tests++; if (obs_addr_q.size() != 0) begin failed++; $display("FAIL empty_writes: got %0d expected 0", obs_addr_q.size()); end
        tests++; if ({done_o, cpu_start_o, err_o} !== 3'b110) begin failed++; $display("FAIL empty_status: done/start/err got %b expected 110", {done_o, cpu_start_o, err_o}); end
        apply_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 1); send_byte(8'hFF, 0);
        settle();
        tests++; if ({done_o, cpu_start_o, err_o, byte_ready_o} !== 4'b0010) begin failed++; $display("FAIL empty_bad_status: done/start/err/ready got %b expected 0010", {done_o, cpu_start_o, err_o, byte_ready_o}); end
        tests++; if (dbg_state_o !== ERROR) begin failed++; $display("FAIL empty_bad_state: got %0d expected %0d", dbg_state_o, ERROR); end
    endtask

    task automatic test_too_long();
        apply_reset();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        @(negedge clk_i);
        tests++; if (dbg_state_o !== ERROR) begin failed++; $display("FAIL long_state: got %0d expected %0d", dbg_state_o, ERROR); end
        tests++; if ({err_o, byte_ready_o, cpu_start_o, done_o} !== 4'b1000) begin failed++; $display("FAIL long_status: err/ready/start/done got %b expected 1000", {err_o, byte_ready_o, cpu_start_o, done_o}); end
        settle();
        tests++; if (obs_addr_q.size() != 0) begin failed++; $display("FAIL long_writes: got %0d expected 0", obs_addr_q.size()); end
    endtask

    task automatic test_max_len();
        logic [7:0] b;
        apply_reset();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            b = i[7:0];
            send_byte(b, 0);
        end
        send_byte(8'h00, 0);
        settle();
        tests++; if (obs_addr_q.size() != 256) begin failed++; $display("FAIL max_count: got %0d writes expected 256", obs_addr_q.size()); end
        else begin
            tests++; if (obs_data_q[1] !== 32'h04050607) begin failed++; $display("FAIL max_data1: got %h expected 04050607", obs_data_q[1]); end
            tests++; if (obs_addr_q[255] !== 32'h3FC) begin failed++; $display("FAIL max_addr_last: got %h expected 3fc", obs_addr_q[255]); end
            tests++; if (obs_data_q[255] !== 32'hFCFDFEFF) begin failed++; $display("FAIL max_data_last: got %h expected fcfdfeff", obs_data_q[255]); end
        end
        tests++; if (done_o !== 1'b1) begin failed++; $display("FAIL max_done: got %b expected 1", done_o); end
    endtask

    task automatic test_bad_csum();
        apply_reset();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_word(32'hCAFEF00D, 0);
        send_word(32'h12345678, 0);
        send_byte(8'hC0, 0);
        settle();
        tests++; if (obs_addr_q.size() != 2) begin failed++; $display("FAIL badcs_count: got %0d writes expected 2", obs_addr_q.size()); end
        else begin
            tests++; if (obs_data_q[1] !== 32'h12345678 || obs_addr_q[1] !== 32'h4) begin failed++; $display("FAIL badcs_write1: got %h@%h expected 12345678@4", obs_data_q[1], obs_addr_q[1]); end
        end
        tests++; if ({err_o, cpu_start_o, done_o} !== 3'b100) begin failed++; $display("FAIL badcs_status: err/start/done got %b expected 100", {err_o, cpu_start_o, done_o}); end
    endtask

    task automatic test_reset_midload();
        apply_reset();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        apply_reset();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'h76543210, 0);
        send_byte(8'h00, 0);
        settle();
        tests++; if (obs_addr_q.size() != 1) begin failed++; $display("FAIL midrst_count: got %0d writes expected 1", obs_addr_q.size()); end
        else begin
            tests++; if (obs_addr_q[0] !== 32'h0 || obs_data_q[0] !== 32'h76543210) begin failed++; $display("FAIL midrst_write: got %h@%h expected 76543210@0", obs_data_q[0], obs_addr_q[0]); end
        end
        tests++; if (done_o !== 1'b1) begin failed++; $display("FAIL midrst_done: got %b expected 1", done_o); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_empty();
        test_too_long();
        test_max_len();
        test_bad_csum();
        test_reset_midload();
        tests++; if (both_flags != 0) begin failed++; $display("FAIL done_err_exclusive: got %0d cycles with both set expected 0", both_flags); end
        tests++; if (long_pulse != 0) begin failed++; $display("FAIL pulse_width_total: got %0d long pulses expected 0", long_pulse); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
